// File: rtl/decoder2x4_pkg.sv
// decoder2x4_pkg
// Shared types and constants for the registered 2-to-4 decoder:
//   state_e      - two-state FSM encoding (IDLE, HOLD)
//   ONEHOT_xx    - one-hot line patterns {y3,y2,y1,y0} for codes 00..11
//   ONEHOT_NONE  - all lines released
package decoder2x4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [3:0] ONEHOT_NONE = 4'b0000;
    localparam logic [3:0] ONEHOT_00   = 4'b0001;
    localparam logic [3:0] ONEHOT_01   = 4'b0010;
    localparam logic [3:0] ONEHOT_10   = 4'b0100;
    localparam logic [3:0] ONEHOT_11   = 4'b1000;

endpackage : decoder2x4_pkg

// File: rtl/decoder2x4_hold_dec2x4_comb.sv
// dec2x4_comb
// Pure combinational 2-to-4 decoder. Feeds the D input of the output
// register in decoder2x4_hold; it has no state of its own.
// Ports:
//   a1, a0          in   code (a1 = MSB)
//   y3, y2, y1, y0  out  one-hot decode of {a1,a0}
module dec2x4_comb
    import decoder2x4_pkg::*;
(
    input  logic a1,
    input  logic a0,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0
);

    logic [3:0] y;

    // NOTE: every output of a combinational block gets a default before
    // the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y = ONEHOT_NONE;
        unique case ({a1, a0})
            2'b00:   y = ONEHOT_00;
            2'b01:   y = ONEHOT_01;
            2'b10:   y = ONEHOT_10;
            2'b11:   y = ONEHOT_11;
            default: y = ONEHOT_NONE;
        endcase
    end

    assign {y3, y2, y1, y0} = y;

endmodule : dec2x4_comb

// File: rtl/decoder2x4_hold.sv
// decoder2x4_hold
// Registered 2-to-4 decoder with a valid/ready input handshake. An accepted
// code drives its one-hot line for exactly HOLD cycles, then the line is
// released (or replaced without a gap by the next accepted code).
// Parameters:
//   HOLD  cycles each decoded line stays asserted (1..255)
//   CW    hold-counter width, 2**CW > HOLD
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   en              block enable; low aborts a hold and blocks acceptance
//   in_valid        code present on a1,a0
//   a1, a0          code (a1 = MSB)
//   in_ready        block accepts a code this cycle (no path from in_valid)
//   y3..y0          registered one-hot decoded lines
//   out_valid       registered, high while any y line is asserted
module decoder2x4_hold
    import decoder2x4_pkg::state_e;
    import decoder2x4_pkg::IDLE;
#(
    parameter int HOLD = 4,
    parameter int CW   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic in_valid,
    input  logic a1,
    input  logic a0,
    output logic in_ready,
    output logic y3,
    output logic y2,
    output logic y1,
    output logic y0,
    output logic out_valid
);

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("decoder2x4_hold: HOLD must be in 1..255");
    end
    if ((64'd1 << CW) <= HOLD) begin : g_bad_cw
        $error("decoder2x4_hold: CW too narrow for HOLD");
    end

    // The HOLD parameter shadows the state literal of the same name, so the
    // state is always written fully qualified below.
    localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      y_q, y_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      dec_y;
    logic            cnt_zero;
    logic            accept;

    dec2x4_comb u_dec (
        .a1 (a1),
        .a0 (a0),
        .y3 (dec_y[3]),
        .y2 (dec_y[2]),
        .y1 (dec_y[1]),
        .y0 (dec_y[0])
    );

    // Ready depends only on registered state and en; the counter is held at
    // zero in IDLE, but IDLE is named explicitly so intent stays obvious.
    assign cnt_zero = (cnt_q == '0);
    assign in_ready = en & ((state_q == IDLE) | cnt_zero);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;

        if (!en) begin
            // Abort: drop the line and forget the remaining hold time.
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = decoder2x4_pkg::ONEHOT_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = decoder2x4_pkg::HOLD;
                        cnt_d   = RELOAD;
                        y_d     = dec_y;
                    end
                end
                decoder2x4_pkg::HOLD: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (accept) begin
                        // Last hold cycle with a new code: swap lines on the
                        // same edge so there is neither gap nor overlap.
                        cnt_d = RELOAD;
                        y_d   = dec_y;
                    end else begin
                        state_d = IDLE;
                        y_d     = decoder2x4_pkg::ONEHOT_NONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    y_d     = decoder2x4_pkg::ONEHOT_NONE;
                end
            endcase
        end
    end

    // out_valid is its own flop rather than an OR of y_q, so it cannot
    // glitch during a line swap.
    assign out_valid_d = |y_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            y_q         <= decoder2x4_pkg::ONEHOT_NONE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign {y3, y2, y1, y0} = y_q;
    assign out_valid        = out_valid_q;

endmodule : decoder2x4_hold

// File: tb/tb_decoder2x4_hold.sv
// tb_decoder2x4_hold
// Directed bench for decoder2x4_hold: one instance with HOLD = 4 and one
// with HOLD = 1. Inputs change 1 time unit after a rising edge and outputs
// are checked at that same point, away from the active edge.
module tb_decoder2x4_hold;

    logic clk;
    logic rst_n;

    // HOLD = 4 instance
    logic en, in_valid, a1, a0;
    logic in_ready, y3, y2, y1, y0, out_valid;

    // HOLD = 1 instance
    logic en_h1, in_valid_h1, a1_h1, a0_h1;
    logic in_ready_h1, y3_h1, y2_h1, y1_h1, y0_h1, out_valid_h1;

    int n_tests = 0;
    int n_fail  = 0;

    decoder2x4_hold #(.HOLD(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .a1        (a1),
        .a0        (a0),
        .in_ready  (in_ready),
        .y3        (y3),
        .y2        (y2),
        .y1        (y1),
        .y0        (y0),
        .out_valid (out_valid)
    );

    decoder2x4_hold #(.HOLD(1), .CW(8)) dut_h1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_h1),
        .in_valid  (in_valid_h1),
        .a1        (a1_h1),
        .a0        (a0_h1),
        .in_ready  (in_ready_h1),
        .y3        (y3_h1),
        .y2        (y2_h1),
        .y1        (y1_h1),
        .y0        (y0_h1),
        .out_valid (out_valid_h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare the HOLD = 4 instance: {y3..y0}, out_valid, in_ready.
    task automatic check_main(input string tag, input logic [3:0] y_exp,
                              input logic ov_exp, input logic rdy_exp);
        check({tag, ".y"},         {4'b0, y3, y2, y1, y0}, {4'b0, y_exp});
        check({tag, ".out_valid"}, {7'b0, out_valid},      {7'b0, ov_exp});
        check({tag, ".in_ready"},  {7'b0, in_ready},       {7'b0, rdy_exp});
    endtask

    task automatic check_h1(input string tag, input logic [3:0] y_exp,
                            input logic ov_exp, input logic rdy_exp);
        check({tag, ".y"},         {4'b0, y3_h1, y2_h1, y1_h1, y0_h1}, {4'b0, y_exp});
        check({tag, ".out_valid"}, {7'b0, out_valid_h1},               {7'b0, ov_exp});
        check({tag, ".in_ready"},  {7'b0, in_ready_h1},                {7'b0, rdy_exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_y;
        logic [1:0] code;

        rst_n       = 1'b0;
        en          = 1'b0;
        in_valid    = 1'b0;
        {a1, a0}    = 2'b00;
        en_h1       = 1'b0;
        in_valid_h1 = 1'b0;
        {a1_h1, a0_h1} = 2'b00;

        // ---- reset state ----
        #2;
        check_main("reset", 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        en_h1 = 1'b1;
        #1;
        check_main("post_reset", 4'b0000, 1'b0, 1'b1);
        check_h1("post_reset_h1", 4'b0000, 1'b0, 1'b1);
        tick();

        // ---- single code 01, HOLD = 4 ----
        in_valid = 1'b1;
        {a1, a0} = 2'b01;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_main($sformatf("single_k%0d", k), 4'b0010, 1'b1, (k == 3));
            tick();
        end
        check_main("single_end", 4'b0000, 1'b0, 1'b1);

        // ---- back-to-back 00,01,10,11 ----
        in_valid = 1'b1;
        {a1, a0} = 2'b00;
        tick();
        for (int c = 0; c < 4; c++) begin
            exp_y = 4'b0001 << c;
            for (int k = 0; k < 4; k++) begin
                check_main($sformatf("b2b_c%0d_k%0d", c, k), exp_y, 1'b1, (k == 3));
                if (k == 3) begin
                    if (c < 3) begin
                        code = 2'(c + 1);
                        {a1, a0} = code;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                tick();
            end
        end
        check_main("b2b_end", 4'b0000, 1'b0, 1'b1);

        // ---- ignored input: 11 held, switched to 00 while not ready ----
        in_valid = 1'b1;
        {a1, a0} = 2'b11;
        tick();
        check_main("ign_k0", 4'b1000, 1'b1, 1'b0);
        {a1, a0} = 2'b00;
        tick();
        check_main("ign_k1", 4'b1000, 1'b1, 1'b0);
        tick();
        check_main("ign_k2", 4'b1000, 1'b1, 1'b0);
        tick();
        check_main("ign_k3", 4'b1000, 1'b1, 1'b1);
        tick();
        check_main("ign_next", 4'b0001, 1'b1, 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        check_main("ign_end", 4'b0000, 1'b0, 1'b1);

        // ---- abort: en drops 2 cycles into a hold of 10 ----
        in_valid = 1'b1;
        {a1, a0} = 2'b10;
        tick();
        in_valid = 1'b0;
        check_main("abort_k0", 4'b0100, 1'b1, 1'b0);
        tick();
        check_main("abort_k1", 4'b0100, 1'b1, 1'b0);
        en       = 1'b0;
        in_valid = 1'b1;
        {a1, a0} = 2'b01;
        #1;
        check_main("abort_en_low", 4'b0100, 1'b1, 1'b0);
        tick();
        check_main("abort_cleared", 4'b0000, 1'b0, 1'b0);
        tick();
        check_main("abort_still_off", 4'b0000, 1'b0, 1'b0);
        en = 1'b1;
        #1;
        check_main("abort_reenable", 4'b0000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        check_main("abort_redecode", 4'b0010, 1'b1, 1'b0);
        repeat (4) tick();
        check_main("abort_end", 4'b0000, 1'b0, 1'b1);

        // ---- asynchronous reset mid-hold of 10 ----
        in_valid = 1'b1;
        {a1, a0} = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        check_main("rst_pre", 4'b0100, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_main("rst_async", 4'b0000, 1'b0, 1'b1);
        tick();
        rst_n = 1'b1;
        #1;
        check_main("rst_release", 4'b0000, 1'b0, 1'b1);
        tick();
        check_main("rst_idle", 4'b0000, 1'b0, 1'b1);

        // ---- HOLD = 1: 11, 00, 11 on consecutive cycles ----
        in_valid_h1    = 1'b1;
        {a1_h1, a0_h1} = 2'b11;
        #1;
        check_h1("h1_pre", 4'b0000, 1'b0, 1'b1);
        tick();
        check_h1("h1_p0", 4'b1000, 1'b1, 1'b1);
        {a1_h1, a0_h1} = 2'b00;
        tick();
        check_h1("h1_p1", 4'b0001, 1'b1, 1'b1);
        {a1_h1, a0_h1} = 2'b11;
        tick();
        check_h1("h1_p2", 4'b1000, 1'b1, 1'b1);
        in_valid_h1 = 1'b0;
        tick();
        check_h1("h1_end", 4'b0000, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decoder2x4_hold

// File: doc/decoder2x4_hold.md
# decoder2x4_hold

Registered 2-to-4 decoder with a valid/ready input handshake and a programmable output hold time. It is the receiving end of the 4x2 encoder path: it accepts a 2-bit code (a1,a0) and drives the matching one-hot line (y3..y0) for exactly HOLD clock cycles. It then releases the line and accepts the next code. It sits downstream of the encoder, feeding select/strobe lines that need a stable, bounded-width pulse.

## Interface
Parameters:
- HOLD, default 4: cycles each decoded line stays asserted; legal range 1..255.
- CW, default 8: hold-counter width; must satisfy 2^CW > HOLD.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  block enable; low aborts any hold and blocks acceptance.
- in_valid  input  1  code present on a1,a0.
- a1  input  1  code MSB.
- a0  input  1  code LSB.
- in_ready  output  1  block will accept a code this cycle.
- y3, y2, y1, y0  output  1 each  registered one-hot decoded lines.
- out_valid  output  1  high while any y line is asserted.

## Operation
- FSM has two states. IDLE: y3..y0 = 0000, out_valid = 0. HOLD: exactly one y line is high.
- Accept is `in_valid & in_ready & en`. On accept, {a1,a0} is captured and the decode is 00→y0, 01→y1, 10→y2, 11→y3.
- The counter loads HOLD-1 on accept and decrements once per HOLD cycle.
- IDLE → HOLD on accept.
- HOLD → HOLD when the counter is non-zero: decrement, outputs unchanged.
- HOLD at counter == 0 with an accept: reload the counter, switch to the new line. Back-to-back codes leave no gap and no overlap.
- HOLD at counter == 0 without an accept: go to IDLE and clear the outputs.
- in_ready = en & (state == IDLE | counter == 0). It is combinational from the registered state, with no path from in_valid.
- in_valid while in_ready = 0 is ignored. The sender holds the code until it is accepted.
- en low in HOLD: go to IDLE next edge, outputs cleared, counter cleared. A code presented in the same cycle is not accepted.
- HOLD = 1: each accepted code produces a single-cycle pulse, and in_ready stays high continuously.
- Reset (asynchronous, any time including mid-hold): state IDLE, counter 0, y3..y0 = 0000, out_valid = 0. in_ready then equals en.

## Timing
- Latency is 1 cycle. A code accepted at edge N appears on y after edge N and stays through edge N+HOLD.
- The line deasserts after edge N+HOLD, unless a new code is accepted at edge N+HOLD, in which case the new line replaces it.
- The y lines and out_valid are glitch-free because they come straight from flops.
- Sustained throughput is one code per HOLD cycles.

## Structure
- Package decoder2x4_pkg holds:
  - the state enum {IDLE, HOLD};
  - the 4-bit one-hot constants for codes 00..11.
- Sub-module dec2x4_comb: a pure combinational 2→4 decoder with inputs a1,a0 and outputs y3..y0. It is instantiated once, feeding the output register's D input.
- The top level contains the FSM, the counter, and the capture/output registers.

## Test plan
- Reset: assert rst_n = 0 mid-hold of code 10. Required: y = 0000 and out_valid = 0 immediately, without waiting for a clock edge. After release with en = 1, in_ready = 1.
- Single code, HOLD = 4: present a1a0 = 01 with in_valid for one accepted cycle. Required: y1 = 1 for exactly 4 cycles starting 1 cycle after accept, then y = 0000; in_ready low for 3 cycles.
- Back-to-back, HOLD = 4: stream 00, 01, 10, 11 with in_valid held high. Required: y0, y1, y2, y3 each high for 4 cycles, contiguous, never two lines high at once, out_valid continuously 1 for 16 cycles.
- Ignored input: change a1a0 from 11 to 00 while in_ready = 0. Required: y3 remains asserted for its full 4 cycles, and 00 is accepted only on the in_ready cycle.
- Abort: drop en 2 cycles into a hold of code 10. Required: y = 0000 on the next edge; in_ready stays 0 while en = 0; a code re-presented after en = 1 is decoded normally.
- HOLD = 1: present the alternating codes 11, 00, 11. Required: one-cycle pulses on y3, y0, y3 on consecutive cycles, with in_ready constantly 1.
